// File: rtl/riscv_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_wb_pkg
// Description : Shared writeback-path constants and types: source encoding
//               and the request record used by upstream writeback sources.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_wb_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_WB_SRC = 3;

  // Writeback source index; doubles as the arbiter requester index.
  typedef enum logic [1:0] {
    WB_ALU    = 2'd0,
    WB_LSU    = 2'd1,
    WB_MULDIV = 2'd2
  } wb_src_e;

  // One writeback request as produced by an execution unit.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Generic round-robin arbiter. Searches from the pointer
//               upward with wrap, grants the first active request (one-hot
//               plus index) and moves the pointer past the winner.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import riscv_wb_pkg::*;
#(
  parameter int NUM_REQ = NUM_WB_SRC,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx
);

  localparam logic [IDX_W:0]   c_NUM  = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_pos;
  logic             w_found;

  // Priority search starting at the pointer; the modulo is an explicit
  // subtract so non-power-of-two requester counts wrap correctly.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_sum       = '0;
    w_pos       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_sum >= c_NUM) begin
        w_sum = w_sum - c_NUM;
      end
      w_pos = w_sum[IDX_W-1:0];
      if (!w_found && i_req[w_pos]) begin
        w_found      = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_grant_idx  = w_pos;
      end
    end
  end

  // Pointer moves to the requester after the winner; held when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance && w_found) begin
      r_ptr <= (o_grant_idx == c_LAST) ? '0 : o_grant_idx + IDX_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the register-file write port between the writeback
//               sources (ALU, LSU, MUL/DIV). Round-robin grant with a
//               valid/ready handshake; the winning write is registered and
//               presented to the register file one cycle later, where it
//               also serves as a bypass source.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
  import riscv_wb_pkg::*;
#(
  parameter int NUM_REQ = riscv_wb_pkg::NUM_WB_SRC,
  parameter int XLEN    = riscv_wb_pkg::XLEN,
  parameter int ADDR_W  = riscv_wb_pkg::REG_ADDR_W,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W  = $clog2(NUM_REQ + 1)
) (
  input  logic                      clk,
  input  logic                      reset_sync,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd_addr_i,
  input  logic [NUM_REQ*XLEN-1:0]   req_rd_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      wr_en_o,
  output logic [ADDR_W-1:0]         rd_addr_o,
  output logic [XLEN-1:0]           rd_data_o,
  output logic                      conflict_o
);

  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_any_grant;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [XLEN-1:0]    w_sel_data;
  logic [CNT_W-1:0]   w_valid_cnt;

  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_addr;
  logic [XLEN-1:0]    r_data;
  logic               r_conflict;

  // Requests are masked during reset so no requester sees ready.
  assign w_req = req_valid_i & {NUM_REQ{~reset_sync}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk         (clk),
    .rst         (reset_sync),
    .i_req       (w_req),
    .i_advance   (~reset_sync),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  assign w_any_grant = |w_grant;
  assign req_ready_o = w_grant;

  // Select the grantee's address and data slices.
  always_comb begin
    w_sel_addr = req_rd_addr_i[int'(w_grant_idx)*ADDR_W +: ADDR_W];
    w_sel_data = req_rd_data_i[int'(w_grant_idx)*XLEN +: XLEN];
  end

  // Count active requesters for the contention flag.
  always_comb begin
    w_valid_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_valid_cnt = w_valid_cnt + CNT_W'(req_valid_i[i]);
    end
  end

  // Output stage: register the granted write; writes to x0 complete the
  // handshake but never assert the write enable. Address/data hold when idle
  // so the last write stays visible for forwarding comparisons.
  always_ff @(posedge clk or posedge reset_sync) begin
    if (reset_sync) begin
      r_wr_en    <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= (w_valid_cnt > CNT_W'(1));
      if (w_any_grant) begin
        r_wr_en <= (w_sel_addr != '0);
        r_addr  <= w_sel_addr;
        r_data  <= w_sel_data;
      end else begin
        r_wr_en <= 1'b0;
      end
    end
  end

  assign wr_en_o    = r_wr_en;
  assign rd_addr_o  = r_addr;
  assign rd_data_o  = r_data;
  assign conflict_o = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed, table-driven self-checking bench for
//               regfile_wb_arbiter, plus hand-written reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam logic [63:0] c_D0 = 64'h0000_0000_AAAA_0000;
  localparam logic [63:0] c_D1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] c_D2 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] c_DB = 64'hDEADBEEF_00000001;

  logic         clk = 1'b0;
  logic         reset_sync;
  logic [2:0]   req_valid_i;
  logic [14:0]  req_rd_addr_i;
  logic [191:0] req_rd_data_i;
  logic [2:0]   req_ready_o;
  logic         wr_en_o;
  logic [4:0]   rd_addr_o;
  logic [63:0]  rd_data_o;
  logic         conflict_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] rf [32];
  logic [31:0] r_seen = '0;

  regfile_wb_arbiter dut (
    .clk           (clk),
    .reset_sync    (reset_sync),
    .req_valid_i   (req_valid_i),
    .req_rd_addr_i (req_rd_addr_i),
    .req_rd_data_i (req_rd_data_i),
    .req_ready_o   (req_ready_o),
    .wr_en_o       (wr_en_o),
    .rd_addr_o     (rd_addr_o),
    .rd_data_o     (rd_data_o),
    .conflict_o    (conflict_o)
  );

  always #5 clk = ~clk;

  // Register-file model fed from the write port.
  always @(posedge clk) begin
    if (wr_en_o) begin
      rf[rd_addr_o]     <= rd_data_o;
      r_seen[rd_addr_o] <= 1'b1;
    end
  end

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  a0, a1, a2;
    logic [2:0]  ready;
    logic        wr;
    logic [4:0]  addr;
    logic [63:0] data;
    logic        conf;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // valid  a0 a1 a2  ready  wr addr data conf   (pointer state in comment)
    tbl[0]  = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b001, 1'b1, 5'd1, c_D0, 1'b1}; // p0->1
    tbl[1]  = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b010, 1'b1, 5'd2, c_D1, 1'b1}; // p1->2
    tbl[2]  = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b100, 1'b1, 5'd3, c_D2, 1'b1}; // p2->0
    tbl[3]  = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b001, 1'b1, 5'd1, c_D0, 1'b1}; // p0->1
    tbl[4]  = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b010, 1'b1, 5'd2, c_D1, 1'b1}; // p1->2
    tbl[5]  = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b100, 1'b1, 5'd3, c_D2, 1'b1}; // p2->0
    tbl[6]  = '{3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 5'd3, c_D2, 1'b0}; // idle, hold
    tbl[7]  = '{3'b001, 5'd5, 5'd0, 5'd0, 3'b001, 1'b1, 5'd5, c_D0, 1'b0}; // p0->1
    tbl[8]  = '{3'b010, 5'd0, 5'd0, 5'd0, 3'b010, 1'b0, 5'd0, c_D1, 1'b0}; // x0, p1->2
    tbl[9]  = '{3'b010, 5'd0, 5'd7, 5'd0, 3'b010, 1'b1, 5'd7, c_D1, 1'b0}; // skip, p2->2
    tbl[10] = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b100, 1'b1, 5'd3, c_D2, 1'b1}; // p2->0
    tbl[11] = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b001, 1'b1, 5'd1, c_D0, 1'b1}; // p0->1
    tbl[12] = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b010, 1'b1, 5'd2, c_D1, 1'b1}; // p1->2
    tbl[13] = '{3'b101, 5'd4, 5'd0, 5'd6, 3'b100, 1'b1, 5'd6, c_D2, 1'b1}; // p2->0
    tbl[14] = '{3'b110, 5'd0, 5'd8, 5'd9, 3'b010, 1'b1, 5'd8, c_D1, 1'b1}; // p0->2
    tbl[15] = '{3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 5'd8, c_D1, 1'b0}; // idle

    // Reset held three cycles with every requester active.
    reset_sync    = 1'b1;
    req_valid_i   = 3'b111;
    req_rd_addr_i = {5'd3, 5'd2, 5'd1};
    req_rd_data_i = {c_D2, c_D1, c_D0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready",  64'(req_ready_o), 64'd0);
    chk("reset_wr_en",  64'(wr_en_o),     64'd0);
    chk("reset_addr",   64'(rd_addr_o),   64'd0);
    chk("reset_data",   rd_data_o,        64'd0);
    chk("reset_conf",   64'(conflict_o),  64'd0);
    reset_sync = 1'b0;

    // Table vectors: ready checked combinationally before the edge,
    // registered outputs checked just after it.
    for (int i = 0; i < 16; i++) begin
      req_valid_i   = tbl[i].valid;
      req_rd_addr_i = {tbl[i].a2, tbl[i].a1, tbl[i].a0};
      req_rd_data_i = {c_D2, c_D1, c_D0};
      #1;
      chk($sformatf("v%0d_ready", i), 64'(req_ready_o), 64'(tbl[i].ready));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wr_en", i), 64'(wr_en_o),    64'(tbl[i].wr));
      chk($sformatf("v%0d_addr", i),  64'(rd_addr_o),  64'(tbl[i].addr));
      chk($sformatf("v%0d_data", i),  rd_data_o,       tbl[i].data);
      chk($sformatf("v%0d_conf", i),  64'(conflict_o), 64'(tbl[i].conf));
      @(negedge clk);
    end

    // Single ALU write (pointer at 2, wraps to requester 0).
    req_valid_i   = 3'b001;
    req_rd_addr_i = {5'd0, 5'd0, 5'd5};
    req_rd_data_i = {c_D2, c_D1, c_DB};
    #1;
    chk("single_ready", 64'(req_ready_o), 64'b001);
    @(posedge clk);
    #1;
    chk("single_wr_en", 64'(wr_en_o),   64'd1);
    chk("single_addr",  64'(rd_addr_o), 64'd5);
    chk("single_data",  rd_data_o,      c_DB);
    @(negedge clk);
    req_valid_i = 3'b000;
    @(posedge clk);
    #1;
    chk("single_idle_wr_en", 64'(wr_en_o), 64'd0);
    chk("single_rf5", rf[5], c_DB);
    @(negedge clk);

    // Reset mid-transfer: write to x11 registered, then reset before the
    // edge that would commit it; a further LSU grant is also dropped.
    req_valid_i   = 3'b001;
    req_rd_addr_i = {5'd0, 5'd9, 5'd11};
    @(posedge clk);
    #1;
    chk("mid_wr_en_before", 64'(wr_en_o), 64'd1);
    @(negedge clk);
    req_valid_i = 3'b010;
    #1;
    chk("mid_ready_lsu", 64'(req_ready_o), 64'b010);
    #2;
    reset_sync = 1'b1;
    #1;
    chk("mid_wr_en_immediate", 64'(wr_en_o),     64'd0);
    chk("mid_ready_in_reset",  64'(req_ready_o), 64'd0);
    @(posedge clk);
    #1;
    chk("mid_wr_en_held", 64'(wr_en_o),   64'd0);
    chk("mid_addr_clear", 64'(rd_addr_o), 64'd0);
    @(negedge clk);
    reset_sync    = 1'b0;
    req_valid_i   = 3'b111;
    req_rd_addr_i = {5'd3, 5'd2, 5'd1};
    #1;
    chk("post_reset_ready", 64'(req_ready_o), 64'b001);
    @(posedge clk);
    #1;
    req_valid_i = 3'b000;
    chk("rf_no_x11_write", 64'(r_seen[11]), 64'd0);
    chk("rf_no_x9_write",  64'(r_seen[9]),  64'd0);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between NUM_REQ writeback sources: ALU, LSU and MUL/DIV.
- Arbitration is round-robin, with a valid/ready handshake per source.
- The winning write is registered and driven onto the register file's wr_en/rd_addr/rd_data inputs one cycle later.
- The registered write stage also serves as a forwarding source for operand bypass.

Parameters:
NUM_REQ, 3, number of writeback requesters (index 0=ALU, 1=LSU, 2=MULDIV)
XLEN, 64, register data width
ADDR_W, 5, register address width

Ports:
clk  input  1  system clock
reset_sync  input  1  reset; asynchronous, active-high
req_valid_i  input  NUM_REQ  requester i has a write pending
req_rd_addr_i  input  NUM_REQ*ADDR_W  flat-packed destination addresses, slice i = [i*ADDR_W +: ADDR_W]
req_rd_data_i  input  NUM_REQ*XLEN  flat-packed write data, slice i = [i*XLEN +: XLEN]
req_ready_o  input-side handshake, output  NUM_REQ  one-hot grant; write accepted when valid & ready
wr_en_o  output  1  register-file write enable
rd_addr_o  output  ADDR_W  register-file write address
rd_data_o  output  XLEN  register-file write data
conflict_o  output  1  registered pulse: more than one valid in the previous cycle

Behaviour:
- Reset: all outputs 0; rr_ptr = 0; req_ready_o = 0 while reset_sync is high.
- Clocking: all state updates on posedge clk; reset_sync clears state immediately.
- Arbitration is combinational within a cycle:
  - Search order is rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - The first requester with valid set is granted.
  - req_ready_o[g] = 1 only for the grantee; at most one bit is set.
  - req_ready_o may depend on req_valid_i. Requesters must not make valid depend on ready.
- Handshake: a requester holds valid/addr/data stable until it sees ready. The transfer completes in the cycle where valid & ready are both 1.
- rr_ptr update:
  - On a grant to g: rr_ptr <= (g+1) mod NUM_REQ, with explicit wrap at NUM_REQ-1 (non-power-of-two safe).
  - No grant: rr_ptr unchanged.
- Latency: a grant in cycle N produces wr_en_o/rd_addr_o/rd_data_o in cycle N+1. This gives a throughput of one write per cycle.
- Output stage:
  - On grant: wr_en_o <= (addr != 0); rd_addr_o and rd_data_o load the grantee's slices.
  - No grant: wr_en_o <= 0; rd_addr_o and rd_data_o hold their previous values.
- x0 writes: the handshake completes normally, but wr_en_o stays 0 in N+1.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles.
- Same-address writes from two sources in one cycle: the arbiter serialises them in round-robin order. Ordering correctness is the issue logic's responsibility; the arbiter does no hazard detection.
- conflict_o <= (popcount(req_valid_i) > 1), updated every cycle.
- Forwarding: consumers compare against rd_addr_o while wr_en_o = 1 to bypass the pending write. The register file also has the data readable from N+2.
- Reset mid-operation: the pending output-stage write is discarded (wr_en_o forced to 0). Requesters see no ready and must retry after reset.

Decomposition:
- Shared package riscv_wb_pkg:
  - XLEN, REG_ADDR_W, NUM_WB_SRC constants.
  - wb_src_e enum (WB_ALU=0, WB_LSU=1, WB_MULDIV=2).
  - wb_req_t struct {valid, addr, data} for upstream use.
- Sub-module rr_arbiter (generic NUM_REQ round-robin):
  - Inputs: req vector, advance strobe.
  - Outputs: one-hot grant, grant index.
  - Owns rr_ptr.
- Top level: unpacking, output register stage, conflict flag.

Test Plan:
- Reset: hold reset_sync for 3 cycles with all valids=1 -> req_ready_o=0, wr_en_o=0, rd_addr_o=0, rd_data_o=0; first post-reset grant goes to requester 0.
- Single write: ALU valid, addr=5, data=0xDEADBEEF_00000001 in cycle N -> req_ready_o=3'b001 in N; in N+1 wr_en_o=1, rd_addr_o=5, rd_data_o=0xDEADBEEF_00000001; N+2 wr_en_o=0.
- Round-robin: all three valid continuously with addrs 1/2/3 -> grant sequence 0,1,2,0,1,2; rd_addr_o sequence 1,2,3,1,… one cycle later; conflict_o=1 throughout.
- x0 suppression: LSU valid, addr=0, data=0xFF -> ready asserted, wr_en_o=0 in N+1; rr_ptr advances to 2.
- Wrap/skip: rr_ptr=2 with only requester 1 valid -> requester 1 granted; rr_ptr becomes 2; next grant order 2,0,1.
- Reset mid-transfer: grant in N, assert reset_sync before clock N+1 edge -> wr_en_o=0 immediately and stays 0; no write reaches the regfile model.
